// File: rtl/s3g_pkg.sv
// S3G packet link shared definitions.
// Framing constants, CRC polynomial and FSM state encoding.
package s3g_pkg;

  localparam logic [7:0] S3G_START       = 8'hD5;
  localparam logic [7:0] S3G_CRC_POLY    = 8'h8C;
  localparam int         S3G_MAX_PAYLOAD = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CRC     = 3'd4,
    ST_WAIT    = 3'd5
  } s3g_state_e;

endpackage

// File: rtl/s3g_crc8.sv
// Dallas/Maxim CRC-8 single-byte step (reflected, LSB first).
// Purely combinational; shared by the tx and rx sides.
module s3g_crc8
  import s3g_pkg::*;
(
  input  logic [7:0] crc_i,
  input  logic [7:0] data_i,
  output logic [7:0] crc_o
);

  logic [7:0] c;

  always_comb begin
    c = crc_i ^ data_i;
    for (int i = 0; i < 8; i++) begin
      if (c[0]) c = (c >> 1) ^ S3G_CRC_POLY;
      else      c = c >> 1;
    end
    crc_o = c;
  end

endmodule

// File: rtl/s3g_tx.sv
// S3G packet transmitter: frames the payload buffer as
// start, length, payload, CRC8 and feeds the UART byte-wise.
module s3g_tx
  import s3g_pkg::*;
#(
  parameter int MAX_PAYLOAD = S3G_MAX_PAYLOAD,
  parameter int ADDR_W      = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              send,
  input  logic [7:0]        send_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        tx_data,
  output logic              tx_wr,
  input  logic              tx_done
);

  logic [7:0] mem_q [MAX_PAYLOAD];

  s3g_state_e state_q;
  s3g_state_e ret_q;
  logic [7:0] len_q;
  logic [7:0] idx_q;
  logic [7:0] crc_q;
  logic [7:0] crc_d;
  logic [7:0] byte_d;
  logic       busy_q;
  logic       done_q;
  logic       err_q;
  logic       tx_wr_q;
  logic [7:0] tx_data_q;
  logic       len_ok;

  assign byte_d = mem_q[idx_q[ADDR_W-1:0]];
  assign len_ok = (send_len != 8'd0)
               && (32'(send_len) <= MAX_PAYLOAD);

  s3g_crc8 u_crc (
    .crc_i  (crc_q),
    .data_i (byte_d),
    .crc_o  (crc_d)
  );

  always_ff @(posedge clk) begin
    if (wr_en && !busy_q && (32'(wr_addr) < MAX_PAYLOAD))
      mem_q[wr_addr] <= wr_data;
  end

  // Outputs are loaded on the edge entering a send state,
  // so tx_wr is visible during that state's single cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ret_q     <= ST_IDLE;
      len_q     <= 8'd0;
      idx_q     <= 8'd0;
      crc_q     <= 8'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      tx_wr_q   <= 1'b0;
      tx_data_q <= 8'd0;
    end else begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      tx_wr_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (send && len_ok) begin
            len_q     <= send_len;
            idx_q     <= 8'd0;
            crc_q     <= 8'd0;
            busy_q    <= 1'b1;
            state_q   <= ST_START;
            tx_wr_q   <= 1'b1;
            tx_data_q <= S3G_START;
          end else if (send) begin
            err_q <= 1'b1;
          end
        end
        ST_START, ST_LEN, ST_PAYLOAD, ST_CRC: begin
          ret_q   <= state_q;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (tx_done) begin
            if (ret_q == ST_START) begin
              state_q   <= ST_LEN;
              tx_wr_q   <= 1'b1;
              tx_data_q <= len_q;
            end else if (ret_q == ST_CRC) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (ret_q == ST_LEN || idx_q < len_q) begin
              state_q   <= ST_PAYLOAD;
              tx_wr_q   <= 1'b1;
              tx_data_q <= byte_d;
              crc_q     <= crc_d;
              idx_q     <= idx_q + 8'd1;
            end else begin
              state_q   <= ST_CRC;
              tx_wr_q   <= 1'b1;
              tx_data_q <= crc_q;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign tx_wr   = tx_wr_q;
  assign tx_data = tx_data_q;

endmodule

// File: tb/tb_s3g_tx.sv
// Testbench for s3g_tx: UART responder model, byte-stream
// scoreboard and a bit-serial CRC-8 reference.
module tb_s3g_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       send;
  logic [7:0] send_len;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_done;
  logic       model_done = 1'b0;
  logic       force_done = 1'b0;

  assign tx_done = model_done | force_done;

  always #5 clk = ~clk;

  s3g_tx dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .send     (send),
    .send_len (send_len),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .tx_data  (tx_data),
    .tx_wr    (tx_wr),
    .tx_done  (tx_done)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [32];
  logic [7:0] got [$];
  logic [7:0] last_byte = 8'd0;
  int cyc = 0;
  int dly = 0;
  int done_cyc = 0;
  bit pend = 1'b0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] crc_ref(input logic [7:0] c,
                                         input logic [7:0] d);
    logic fb;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ d[i];
      c  = c >> 1;
      if (fb) c = c ^ 8'h8C;
    end
    return c;
  endfunction

  // UART responder: tx_done ten cycles after each tx_wr.
  always @(negedge clk) begin
    cyc++;
    model_done <= 1'b0;
    if (done) begin
      done_cnt++;
      chk("lat_done", cyc, done_cyc + 1);
      chk("busy_at_done", {31'd0, busy}, 0);
    end
    if (err) err_cnt++;
    if (tx_wr) begin
      if (pend) chk("lat_wr", cyc, done_cyc + 1);
      pend = 1'b0;
      got.push_back(tx_data);
      last_byte = tx_data;
      wr_cnt++;
      dly = 10;
    end else if (busy !== 1'b1) begin
      dly  = 0;
      pend = 1'b0;
    end else if (dly > 0) begin
      dly--;
      if (dly == 0) begin
        model_done <= 1'b1;
        done_cyc = cyc;
        pend = 1'b1;
        chk("tx_data_stable", {24'd0, tx_data}, {24'd0, last_byte});
      end
    end
  end

  task automatic wr(input int a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'(a); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    mem[a] = d;
  endtask

  task automatic run_pkt(input int len, input bit interfere,
                         input bit coincide);
    logic [7:0] exp [$];
    logic [7:0] c;
    int t0, e0;
    c = 8'd0;
    exp = {8'hD5, 8'(len)};
    for (int i = 0; i < len; i++) begin
      exp.push_back(mem[i]);
      c = crc_ref(c, mem[i]);
    end
    exp.push_back(c);
    got.delete();
    t0 = done_cnt;
    e0 = err_cnt;
    @(negedge clk);
    send = 1'b1; send_len = 8'(len);
    @(negedge clk);
    send = 1'b0;
    chk("start_wr", {31'd0, tx_wr}, 1);
    chk("start_data", {24'd0, tx_data}, 32'hD5);
    chk("busy_on", {31'd0, busy}, 1);
    if (coincide) begin
      force_done = 1'b1;
      @(negedge clk);
      force_done = 1'b0;
    end
    if (interfere) begin
      repeat (3) @(negedge clk);
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = ~mem[0];
      send = 1'b1; send_len = 8'd1;
      @(negedge clk);
      wr_en = 1'b0; send = 1'b0;
    end
    for (int n = 0; n < 5000 && done !== 1'b1; n++) @(negedge clk);
    chk("done_seen", {31'd0, done}, 1);
    chk("busy_off", {31'd0, busy}, 0);
    @(negedge clk);
    chk("n_bytes", got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk($sformatf("byte%0d", i),
          {24'd0, (i < got.size()) ? got[i] : 8'hxx},
          {24'd0, exp[i]});
    chk("done_once", done_cnt - t0, 1);
    chk("no_err", err_cnt - e0, 0);
  endtask

  task automatic send_bad(input int len);
    int t0, e0;
    t0 = wr_cnt;
    e0 = err_cnt;
    @(negedge clk);
    send = 1'b1; send_len = 8'(len);
    @(negedge clk);
    send = 1'b0;
    chk("err_pulse", {31'd0, err}, 1);
    chk("err_busy", {31'd0, busy}, 0);
    @(negedge clk);
    chk("err_clear", {31'd0, err}, 0);
    repeat (3) @(negedge clk);
    chk("err_no_wr", wr_cnt - t0, 0);
    chk("err_count", err_cnt - e0, 1);
  endtask

  initial begin
    int t0;
    int len;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 8'd0;
    send = 1'b0; send_len = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_wr", {31'd0, tx_wr}, 0);
    chk("rst_data", {24'd0, tx_data}, 0);
    rst_n = 1'b1;

    wr(0, 8'h01);
    run_pkt(1, 1'b0, 1'b0);
    chk("crc_01", {24'd0, got.size() == 4 ? got[3] : 8'hxx}, 32'h5E);
    wr(0, 8'h02);
    run_pkt(1, 1'b0, 1'b0);
    chk("crc_02", {24'd0, got.size() == 4 ? got[3] : 8'hxx}, 32'hBC);
    wr(0, 8'h00);
    run_pkt(1, 1'b0, 1'b0);
    chk("crc_00", {24'd0, got.size() == 4 ? got[3] : 8'hxx}, 32'h00);

    send_bad(0);
    send_bad(33);

    for (int i = 0; i < 32; i++) wr(i, 8'(i));
    run_pkt(32, 1'b0, 1'b0);
    run_pkt(32, 1'b1, 1'b0);
    run_pkt(1, 1'b0, 1'b0);

    t0 = wr_cnt;
    repeat (3) begin
      @(negedge clk); force_done = 1'b1;
      @(negedge clk); force_done = 1'b0;
    end
    repeat (2) @(negedge clk);
    chk("spur_no_wr", wr_cnt - t0, 0);
    chk("spur_busy", {31'd0, busy}, 0);
    run_pkt(3, 1'b0, 1'b1);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 32; i++) wr(i, 8'($urandom));
      len = $urandom_range(1, 32);
      run_pkt(len, 1'b0, r[0]);
    end

    got.delete();
    @(negedge clk);
    send = 1'b1; send_len = 8'd1;
    @(negedge clk);
    send = 1'b0;
    for (int n = 0; n < 200 && got.size() < 2; n++) @(negedge clk);
    chk("pre_rst_bytes", got.size(), 2);
    rst_n = 1'b0;
    t0 = wr_cnt;
    @(negedge clk);
    chk("mid_rst_wr", {31'd0, tx_wr}, 0);
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_done", {31'd0, done}, 0);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("mid_rst_quiet", wr_cnt - t0, 0);
    run_pkt(1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
